misr_signature_engine: RTL and testbench

- Parametrised multiple-input signature register (MISR) for built-in self-test (BIST) response compaction.
- Compacts a run of LEN valid WIDTH-bit response words into a signature and compares the result against a golden value.
- Reports done/pass to the BIST controller.
- Successor to the fixed 5-bit MISR: adds configurable width, feedback polynomial and seed, a counted session with a valid qualifier, an abort, and an on-chip compare.

---
 rtl/misr_signature_engine.sv | 102 ++++++++++
 tb/tb_misr_signature_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_signature_engine.sv
// Multiple-input signature register for BIST response compaction.
// Runs a counted, valid-qualified session and compares the final signature against a golden value.
module misr_signature_engine #(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = 5'b11011,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] len,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sig_q, sig_d;
    logic [WIDTH-1:0]   next_sig;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               pass_q, pass_d;

    // One compaction step: shift, fold the MSB back through the taps, absorb the word.
    always_comb begin
        next_sig    = '0;
        next_sig[0] = (POLY[0] & sig_q[WIDTH-1]) ^ din[0];
        for (int i = 1; i < int'(WIDTH); i++) begin
            next_sig[i] = sig_q[i-1] ^ (POLY[i] & sig_q[WIDTH-1]) ^ din[i];
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        rem_d   = rem_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                // Abort outranks start here, so a simultaneous pair never opens a session.
                if (!abort && start) begin
                    sig_d = SEED;
                    if (len != '0) begin
                        rem_d   = len;
                        pass_d  = 1'b0;
                        state_d = StRun;
                    end else begin
                        pass_d  = (SEED == golden);
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = StIdle;
                end else if (din_valid) begin
                    sig_d = next_sig;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        pass_d  = (next_sig == golden);
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    pass_d = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            rem_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            rem_q   <= rem_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_misr_signature_engine.sv
// Bench for misr_signature_engine: per-cycle compare against a session-level model,
// plus literal signature/flag checks from hand-worked examples.
module tb_misr_signature_engine;

    localparam logic [4:0] POLY5 = 5'b11011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0, din_valid = 1'b0;
    logic [15:0] len = '0;
    logic [4:0]  din = '0, golden = '0;
    logic        busy, done, pass;
    logic [4:0]  signature;

    logic        start_b = 1'b0, abort_b = 1'b0, din_valid_b = 1'b0;
    logic [15:0] len_b = '0;
    logic [7:0]  din_b = '0, golden_b = '0;
    logic        busy_b, done_b, pass_b;
    logic [7:0]  signature_b;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    misr_signature_engine dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .din_valid(din_valid), .din(din), .golden(golden),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    misr_signature_engine #(
        .WIDTH(8), .POLY(8'h1D), .SEED(8'hFF), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .len(len_b),
        .din_valid(din_valid_b), .din(din_b), .golden(golden_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(signature_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature arithmetic as polynomial multiply-by-x mod POLY, plus the new word.
    function automatic logic [4:0] step5(input logic [4:0] s, input logic [4:0] d);
        logic [5:0] wide;
        wide = {s, 1'b0};
        if (wide[5]) wide[4:0] = wide[4:0] ^ POLY5;
        return wide[4:0] ^ d;
    endfunction

    // Session model: in_session while words are still owed, finishing for one cycle after.
    logic       m_in_session, m_finishing, m_pass;
    logic [4:0] m_sig;
    int         m_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in_session = 1'b0; m_finishing = 1'b0; m_pass = 1'b0;
            m_sig = '0; m_left = 0;
        end else if (m_in_session) begin
            if (abort) begin
                m_in_session = 1'b0; m_pass = 1'b0;
            end else if (din_valid) begin
                m_sig  = step5(m_sig, din);
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_in_session = 1'b0; m_finishing = 1'b1; m_pass = (m_sig == golden);
                end
            end
        end else if (m_finishing) begin
            m_finishing = 1'b0;
            if (abort) m_pass = 1'b0;
        end else if (start && !abort) begin
            m_sig = '0;
            if (len == 0) begin
                m_finishing = 1'b1; m_pass = (golden == 5'd0);
            end else begin
                m_in_session = 1'b1; m_left = int'(len); m_pass = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", {31'd0, busy}, {31'd0, m_in_session});
            chk("done", {31'd0, done}, {31'd0, m_finishing});
            chk("pass", {31'd0, pass}, {31'd0, m_pass});
            chk("signature", {27'd0, signature}, {27'd0, m_sig});
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [4:0] w);
        din_valid = 1'b1; din = w;
        tick();
    endtask

    task automatic gap();
        din_valid = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        repeat (2) tick();
        chk("reset_sig", {27'd0, signature}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_pass", {31'd0, pass}, 32'd0);
        chk("reset_sig_b", {24'd0, signature_b}, 32'hFF);
        #3 rst = 1'b1;
        tick();

        // Back-to-back stream, matching golden
        golden = 5'b10011; len = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        base = done_cnt;
        word(5'b00001); chk("t1_w1", {27'd0, signature}, 32'b00001);
        word(5'b00000); chk("t1_w2", {27'd0, signature}, 32'b00010);
        word(5'b10000); chk("t1_w3", {27'd0, signature}, 32'b10100);
        word(5'b00000); chk("t1_w4", {27'd0, signature}, 32'b10011);
        din_valid = 1'b0;
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_pass", {31'd0, pass}, 32'd1);
        tick();
        chk("t1_done_low", {31'd0, done}, 32'd0);
        chk("t1_sig_held", {27'd0, signature}, 32'b10011);
        chk("t1_pass_held", {31'd0, pass}, 32'd1);

        // Gaps mid-stream, stray start during RUN, golden mismatch
        golden = 5'b10100; start = 1'b1;
        tick();
        start = 1'b0;
        base = done_cnt;
        word(5'b00001); word(5'b00000);
        start = 1'b1; gap(); start = 1'b0; gap();
        chk("t2_gap_sig", {27'd0, signature}, 32'b00010);
        chk("t2_gap_busy", {31'd0, busy}, 32'd1);
        word(5'b10000); word(5'b00000);
        din_valid = 1'b0;
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_sig", {27'd0, signature}, 32'b10011);
        chk("t2_pass", {31'd0, pass}, 32'd0);
        tick(); tick();
        chk("t2_one_done", done_cnt - base, 32'd1);

        // Zero-length session
        golden = 5'b00000; len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_pass", {31'd0, pass}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_sig", {27'd0, signature}, 32'd0);
        tick();

        // Abort after two words (abort beats a concurrent valid word)
        golden = 5'b10011; len = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        base = done_cnt;
        word(5'b00001); word(5'b00000);
        abort = 1'b1; din_valid = 1'b1; din = 5'b10000;
        tick();
        abort = 1'b0; din_valid = 1'b0;
        chk("t4_idle", {31'd0, busy}, 32'd0);
        chk("t4_frozen", {27'd0, signature}, 32'b00010);
        chk("t4_pass", {31'd0, pass}, 32'd0);
        tick(); tick();
        chk("t4_no_done", done_cnt - base, 32'd0);
        // abort and start together in IDLE: no session
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("t4_abort_wins", {31'd0, busy}, 32'd0);
        // Restart completes normally
        start = 1'b1;
        tick();
        start = 1'b0;
        word(5'b00001); word(5'b00000); word(5'b10000); word(5'b00000);
        din_valid = 1'b0;
        chk("t4_restart_sig", {27'd0, signature}, 32'b10011);
        chk("t4_restart_pass", {31'd0, pass}, 32'd1);
        tick();

        // Asynchronous reset mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        word(5'b00001); word(5'b00000);
        din_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_done", {31'd0, done}, 32'd0);
        chk("t5_rst_sig", {27'd0, signature}, 32'd0);
        chk("t5_rst_pass", {31'd0, pass}, 32'd0);
        tick();
        #2 rst = 1'b1;
        tick();
        // start held high throughout: only one done for the session
        base = done_cnt;
        start = 1'b1;
        tick();
        word(5'b00001); word(5'b00000); word(5'b10000); word(5'b00000);
        din_valid = 1'b0; start = 1'b0;
        tick(); tick();
        chk("t5_one_done", done_cnt - base, 32'd1);

        // 8-bit instance: seed FF, one zero word gives E3
        golden_b = 8'hE3; len_b = 16'd1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("t6_busy", {31'd0, busy_b}, 32'd1);
        din_valid_b = 1'b1; din_b = 8'h00;
        tick();
        din_valid_b = 1'b0;
        chk("t6_sig", {24'd0, signature_b}, 32'hE3);
        chk("t6_done", {31'd0, done_b}, 32'd1);
        chk("t6_pass", {31'd0, pass_b}, 32'd1);
        tick();
        chk("t6_done_low", {31'd0, done_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
